// File: rtl/chunk_assembler.sv
// chunk_assembler: rebuilds a 512-bit chunk, plus the key/nonce/counter header
// in ENCRYP framing, from a 32-bit valid/ready/last stream.
module chunk_assembler #(
  parameter bit CHECK_LAST = 1'b1
) (
  input  logic         chunk_asm_clk,
  input  logic         chunk_asm_reset_n,
  input  logic         encryp_decryp,
  input  logic [31:0]  s_axis_data,
  input  logic         s_axis_valid,
  input  logic         s_axis_last,
  output logic         s_axis_ready,
  input  logic         chunk_out_ready,
  output logic [255:0] public_key,
  output logic [63:0]  nonce,
  output logic [63:0]  counter,
  output logic [511:0] chunk_data_out,
  output logic         header_present,
  output logic         chunk_out_valid,
  output logic         frame_error
);

  typedef enum logic [2:0] {
    RECV_KEY,
    RECV_NONCE,
    RECV_CTR,
    RECV_DATA,
    HOLD,
    DRAIN
  } state_t;

  state_t       state;
  logic [4:0]   cnt;
  logic         busy;
  logic         mode;
  logic [255:0] stg_key;
  logic [63:0]  stg_nonce;
  logic [63:0]  stg_ctr;
  logic [479:0] stg_data;

  logic beat;
  logic last_chk;

  assign beat     = s_axis_valid & s_axis_ready;
  assign last_chk = CHECK_LAST & s_axis_last;

  // Frame sequencing, field assembly, framing checks and output hand-off.
  // cnt holds the number of words still to come in the current field after
  // the present one; busy marks that the key field has started.
  always_ff @(posedge chunk_asm_clk or negedge chunk_asm_reset_n) begin
    if (!chunk_asm_reset_n) begin
      state           <= RECV_KEY;
      cnt             <= '0;
      busy            <= 1'b0;
      mode            <= 1'b0;
      stg_key         <= '0;
      stg_nonce       <= '0;
      stg_ctr         <= '0;
      stg_data        <= '0;
      s_axis_ready    <= 1'b0;
      public_key      <= '0;
      nonce           <= '0;
      counter         <= '0;
      chunk_data_out  <= '0;
      header_present  <= 1'b0;
      chunk_out_valid <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      unique case (state)
        RECV_KEY: begin
          s_axis_ready <= 1'b1;
          if (beat) begin
            if (!busy) mode <= encryp_decryp;
            if (!busy && encryp_decryp) begin
              stg_data <= {stg_data[447:0], s_axis_data};
              cnt      <= 5'd14;
              state    <= RECV_DATA;
            end else begin
              stg_key <= {stg_key[223:0], s_axis_data};
              busy    <= 1'b1;
              if (!busy) begin
                cnt <= 5'd6;
              end else if (cnt == 5'd0) begin
                cnt   <= 5'd1;
                busy  <= 1'b0;
                state <= RECV_NONCE;
              end else begin
                cnt <= cnt - 5'd1;
              end
            end
            if (last_chk) begin
              frame_error <= 1'b1;
              busy        <= 1'b0;
              cnt         <= '0;
              state       <= RECV_KEY;
            end
          end
        end
        RECV_NONCE: begin
          if (beat) begin
            stg_nonce <= {stg_nonce[31:0], s_axis_data};
            if (cnt == 5'd0) begin
              cnt   <= 5'd1;
              state <= RECV_CTR;
            end else begin
              cnt <= cnt - 5'd1;
            end
            if (last_chk) begin
              frame_error <= 1'b1;
              cnt         <= '0;
              state       <= RECV_KEY;
            end
          end
        end
        RECV_CTR: begin
          if (beat) begin
            stg_ctr <= {stg_ctr[31:0], s_axis_data};
            if (cnt == 5'd0) begin
              cnt   <= 5'd15;
              state <= RECV_DATA;
            end else begin
              cnt <= cnt - 5'd1;
            end
            if (last_chk) begin
              frame_error <= 1'b1;
              cnt         <= '0;
              state       <= RECV_KEY;
            end
          end
        end
        RECV_DATA: begin
          if (beat) begin
            stg_data <= {stg_data[447:0], s_axis_data};
            if (cnt != 5'd0) begin
              cnt <= cnt - 5'd1;
              if (last_chk) begin
                frame_error <= 1'b1;
                cnt         <= '0;
                state       <= RECV_KEY;
              end
            end else if (CHECK_LAST && !s_axis_last) begin
              frame_error <= 1'b1;
              state       <= DRAIN;
            end else begin
              chunk_data_out  <= {stg_data, s_axis_data};
              if (!mode) begin
                public_key <= stg_key;
                nonce      <= stg_nonce;
                counter    <= stg_ctr;
              end
              header_present  <= ~mode;
              chunk_out_valid <= 1'b1;
              s_axis_ready    <= 1'b0;
              state           <= HOLD;
            end
          end
        end
        HOLD: begin
          if (chunk_out_ready) begin
            chunk_out_valid <= 1'b0;
            s_axis_ready    <= 1'b1;
            cnt             <= '0;
            state           <= RECV_KEY;
          end
        end
        DRAIN: begin
          if (beat && s_axis_last) begin
            cnt   <= '0;
            state <= RECV_KEY;
          end
        end
        default: begin
          state <= RECV_KEY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_assembler.sv
// tb_chunk_assembler: scoreboard bench with directed scenarios followed by
// randomized good / early-last / missing-last frames.
`timescale 1ns/1ps
module tb_chunk_assembler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         encryp_decryp = 1'b0;
  logic [31:0]  s_axis_data = '0;
  logic         s_axis_valid = 1'b0;
  logic         s_axis_last = 1'b0;
  logic         s_axis_ready;
  logic         chunk_out_ready = 1'b1;
  logic [255:0] public_key;
  logic [63:0]  nonce;
  logic [63:0]  counter;
  logic [511:0] chunk_data_out;
  logic         header_present;
  logic         chunk_out_valid;
  logic         frame_error;

  chunk_assembler #(.CHECK_LAST(1'b1)) dut (
    .chunk_asm_clk     (clk),
    .chunk_asm_reset_n (rst_n),
    .encryp_decryp     (encryp_decryp),
    .s_axis_data       (s_axis_data),
    .s_axis_valid      (s_axis_valid),
    .s_axis_last       (s_axis_last),
    .s_axis_ready      (s_axis_ready),
    .chunk_out_ready   (chunk_out_ready),
    .public_key        (public_key),
    .nonce             (nonce),
    .counter           (counter),
    .chunk_data_out    (chunk_data_out),
    .header_present    (header_present),
    .chunk_out_valid   (chunk_out_valid),
    .frame_error       (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] key;
    logic [63:0]  nonce;
    logic [63:0]  ctr;
    logic [511:0] data;
    logic         hp;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [31:0]  wq[$];
  logic [255:0] m_key = '0;
  logic [63:0]  m_nonce = '0;
  logic [63:0]  m_ctr = '0;
  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_exp = 0;
  int cyc = 0;
  int pop_cyc = -1;
  int first_cyc = -1;
  int rdy_mode = 0;
  int gap_en = 0;

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // chunk_out_ready: 0 = always high, 1 = random, 2 = held low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: chunk_out_ready = 1'b1;
      1: chunk_out_ready = 1'($urandom_range(0, 1));
      default: chunk_out_ready = 1'b0;
    endcase
  end

  // Monitor: compare presented chunk with the scoreboard head every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_error) err_seen++;
      if (chunk_out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chunk: got valid chunk, required none");
        end else begin
          e = sb[0];
          chk("chunk_data", chunk_data_out, e.data);
          chk("public_key", 512'(public_key), 512'(e.key));
          chk("nonce", 512'(nonce), 512'(e.nonce));
          chk("counter", 512'(counter), 512'(e.ctr));
          chk("header_present", 512'(header_present), 512'(e.hp));
          chk("ready_in_hold", 512'(s_axis_ready), 512'(0));
          if (chunk_out_ready) begin
            void'(sb.pop_front());
            pop_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic l, input logic m,
                      input bit first);
    int t;
    @(negedge clk);
    s_axis_data   = w;
    s_axis_last   = l;
    encryp_decryp = m;
    s_axis_valid  = 1'b1;
    t = 0;
    while (!s_axis_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!s_axis_ready) begin
      errors++;
      $display("FAIL send_timeout: ready=%0d required 1", s_axis_ready);
      s_axis_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (first) first_cyc = cyc;
    #1;
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
    if (gap_en != 0) repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_frame(input logic m, input int n, input int lastpos);
    logic mm;
    for (int i = 0; i < n; i++) begin
      mm = (i == 0) ? m : 1'($urandom_range(0, 1));
      send(wq[i], (i + 1 == lastpos), mm, (i == 0));
    end
  endtask

  task automatic fill_rand(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  // Reference: fields are simply the frame's words in arrival order
  task automatic expect_good(input logic m);
    exp_t x;
    int off;
    off = 0;
    if (!m) begin
      for (int i = 0; i < 8; i++) m_key[255-32*i -: 32] = wq[i];
      for (int i = 0; i < 2; i++) m_nonce[63-32*i -: 32] = wq[8+i];
      for (int i = 0; i < 2; i++) m_ctr[63-32*i -: 32] = wq[10+i];
      off = 12;
    end
    x.data = '0;
    for (int i = 0; i < 16; i++) x.data[511-32*i -: 32] = wq[off+i];
    x.key   = m_key;
    x.nonce = m_nonce;
    x.ctr   = m_ctr;
    x.hp    = ~m;
    sb.push_back(x);
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk("scoreboard_drained", 512'(sb.size()), 512'(0));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_key"}, 512'(public_key), 512'(0));
    chk({name, "_nonce_ctr"}, 512'({nonce, counter}), 512'(0));
    chk({name, "_data"}, chunk_data_out, 512'(0));
    chk({name, "_flags"},
        512'({header_present, chunk_out_valid, frame_error, s_axis_ready}),
        512'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    int   k;
    int   n;
    int   typ;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_release", 512'(s_axis_ready), 512'(1));

    // DECRYP 1..16
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(32'(i + 1));
    expect_good(1'b1);
    send_frame(1'b1, 16, 16);
    @(negedge clk);
    chk("valid_after_final", 512'(chunk_out_valid), 512'(1));
    @(negedge clk);
    chk("valid_one_cycle", 512'(chunk_out_valid), 512'(0));

    // ENCRYP header + data
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(32'hA0 + 32'(i));
    wq.push_back(32'hB0);
    wq.push_back(32'hB1);
    wq.push_back(32'hC0);
    wq.push_back(32'hC1);
    for (int i = 0; i < 16; i++) wq.push_back(32'hD0 + 32'(i));
    expect_good(1'b0);
    send_frame(1'b0, 28, 28);
    wait_empty();

    // Back-pressure with the next frame already waiting
    rdy_mode = 2;
    fill_rand(28);
    expect_good(1'b0);
    send_frame(1'b0, 28, 28);
    fill_rand(16);
    expect_good(1'b1);
    fork
      begin
        repeat (10) @(posedge clk);
        rdy_mode = 0;
      end
      send_frame(1'b1, 16, 16);
    join
    chk("restart_latency", 512'(first_cyc), 512'(pop_cyc + 1));
    wait_empty();

    // Early last on word 5, then a good frame
    err_exp++;
    fill_rand(5);
    send_frame(1'b1, 5, 5);
    @(negedge clk);
    chk("early_last_pulse", 512'(frame_error), 512'(1));
    fill_rand(16);
    expect_good(1'b1);
    send_frame(1'b1, 16, 16);
    wait_empty();

    // Missing last: 18 words, last on 18
    err_exp++;
    fill_rand(18);
    for (int i = 0; i < 16; i++) send(wq[i], 1'b0, 1'b1, (i == 0));
    @(negedge clk);
    chk("missing_last_pulse", 512'(frame_error), 512'(1));
    send(wq[16], 1'b0, 1'b1, 1'b0);
    send(wq[17], 1'b1, 1'b1, 1'b0);
    fill_rand(28);
    expect_good(1'b0);
    send_frame(1'b0, 28, 28);
    wait_empty();

    // Async reset after word 10 of an ENCRYP frame
    fill_rand(10);
    send_frame(1'b0, 10, 0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    m_key   = '0;
    m_nonce = '0;
    m_ctr   = '0;
    @(negedge clk) rst_n = 1'b1;
    fill_rand(16);
    expect_good(1'b1);
    send_frame(1'b1, 16, 16);
    wait_empty();

    // Randomized traffic
    gap_en   = 1;
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      m   = 1'($urandom_range(0, 1));
      n   = m ? 16 : 28;
      typ = $urandom_range(0, 9);
      if (typ < 7) begin
        fill_rand(n);
        expect_good(m);
        send_frame(m, n, n);
      end else if (typ < 9) begin
        k = $urandom_range(1, n - 1);
        err_exp++;
        fill_rand(k);
        send_frame(m, k, k);
      end else begin
        k = n + $urandom_range(1, 3);
        err_exp++;
        fill_rand(k);
        send_frame(m, k, k);
      end
    end
    rdy_mode = 0;
    wait_empty();
    repeat (3) @(posedge clk);
    chk("frame_error_count", 512'(err_seen), 512'(err_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
